// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - multi-cycle byte/half/word data memory responder with wait states
//
// Purpose: serves one load/store at a time for the MIPS datapath. A request is
// latched in IDLE, waits WAIT cycles, performs the access, then spends one
// RESP cycle with ready pulsed. Misaligned or illegal-size requests skip the
// wait and respond with err one edge after acceptance.
//
// Ports:
//   CLK       clock; all state changes on the rising edge
//   Reset     asynchronous active-low reset
//   req       request strobe, sampled only in IDLE
//   we        1 = store, 0 = load
//   size      00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext  loads: 1 sign-extends, 0 zero-extends (ignored for words)
//   addr      byte address (wraps modulo 4*2^ADDR_W)
//   wdata     right-aligned store data
//   rdata     extended load result, held until the next completed load
//   ready     one-cycle completion pulse
//   err       misaligned / illegal-size flag, valid with ready
//   busy      high whenever not IDLE
module data_mem_unit #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              bad_q;

  logic [31:0] mem [2**ADDR_W];

  logic              bad_in;
  logic              access;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic [31:0]       ld_word;
  logic [31:0]       st_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Address bits above the wrap boundary are intentionally discarded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign bad_in = (size == 2'b11)
                | ((size == 2'b01) & addr[0])
                | ((size == 2'b10) & (addr[1:0] != 2'b00));

  assign access   = (state == S_WAIT) && (cnt == 4'd0) && !bad_q;
  assign word_idx = addr_q[ADDR_W+1:2];
  assign lane     = addr_q[1:0];
  assign cur_word = mem[word_idx];
  assign busy     = (state != S_IDLE);

  assign byte_v = cur_word[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    ld_word = cur_word;
    case (size_q)
      2'b00:   ld_word = sext_q ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      2'b01:   ld_word = sext_q ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      default: ld_word = cur_word;
    endcase
  end

  // Read-modify-write merge so only the selected lanes change.
  always_comb begin
    st_word = cur_word;
    case (size_q)
      2'b00:   st_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   st_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_word = wdata_q;
    endcase
  end

  // The array is never reset; reset only has to stop a pending write, which
  // it does by forcing state back to IDLE.
  always_ff @(posedge CLK) begin
    if (access && we_q) begin
      mem[word_idx] <= st_word;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            bad_q   <= bad_in;
            cnt     <= WAIT_CNT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bad_q) begin
            // Error responses bypass the wait count entirely.
            ready <= 1'b1;
            err   <= 1'b1;
            state <= S_RESP;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready <= 1'b1;
            if (!we_q) begin
              rdata <= ld_word;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - directed self-checking bench for data_mem_unit
module tb_data_mem_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_a, req_b;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b, busy_a, busy_b;

  int vecs = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  data_mem_unit #(.ADDR_W(8), .WAIT(2)) dut_a (
    .CLK(CLK), .Reset(Reset), .req(req_a), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  data_mem_unit #(.ADDR_W(8), .WAIT(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .req(req_b), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  // Issues one request to instance a (inst=0) or b (inst=1) and reports the
  // number of edges from acceptance to the first ready sample, the result,
  // and how many cycles ready was seen high.
  task automatic txn(input bit inst, input bit w, input logic [1:0] sz,
                     input bit sx, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int pulses);
    logic r, b;
    @(negedge CLK);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    if (inst) req_b = 1'b1; else req_a = 1'b1;
    @(posedge CLK);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = -1; pulses = 0; rd = 'x; er = 1'bx;
    for (int n = 1; n <= 25; n++) begin
      @(posedge CLK);
      #1;
      r = inst ? ready_b : ready_a;
      b = inst ? busy_b : busy_a;
      if (r) begin
        if (lat < 0) begin
          lat = n;
          rd  = inst ? rdata_b : rdata_a;
          er  = inst ? err_b : err_a;
        end
        pulses++;
      end
      if (lat >= 0 && !b) break;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    vecs++;
    if ({rdata_a, ready_a, err_a, busy_a} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_a got rdata=%h ready=%b err=%b busy=%b want all 0", rdata_a, ready_a, err_a, busy_a);
    end
    vecs++;
    if ({rdata_b, ready_b, err_b, busy_b} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_b got rdata=%h ready=%b err=%b busy=%b want all 0", rdata_b, ready_b, err_b, busy_b);
    end
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_word();
    int lat, p; logic [31:0] rd; logic er;
    txn(0, 1, 2'b10, 0, 32'h10, 32'h12345678, lat, rd, er, p);
    vecs++;
    if (lat !== 3 || p !== 1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL store_word got lat=%0d pulses=%0d err=%b want 3 1 0", lat, p, er);
    end
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er, p);
    vecs++;
    if (lat !== 3 || p !== 1 || er !== 1'b0 || rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL load_word got lat=%0d pulses=%0d err=%b rdata=%h want 3 1 0 12345678", lat, p, er, rd);
    end
  endtask

  task automatic test_byte_half();
    int lat, p; logic [31:0] rd; logic er;
    txn(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFFAB, lat, rd, er, p);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'h1234AB78) begin
      miscompares++;
      $display("FAIL byte_merge got %h want 1234ab78", rd);
    end
    txn(0, 0, 2'b00, 1, 32'h11, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'hFFFFFFAB) begin
      miscompares++;
      $display("FAIL lb_signed got %h want ffffffab", rd);
    end
    txn(0, 0, 2'b00, 0, 32'h11, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'h000000AB) begin
      miscompares++;
      $display("FAIL lb_unsigned got %h want 000000ab", rd);
    end
    txn(0, 0, 2'b01, 1, 32'h12, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'h00001234) begin
      miscompares++;
      $display("FAIL lh_signed_pos got %h want 00001234", rd);
    end
    txn(0, 1, 2'b01, 0, 32'h16, 32'h00008001, lat, rd, er, p);
    txn(0, 0, 2'b01, 1, 32'h16, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'hFFFF8001) begin
      miscompares++;
      $display("FAIL lh_signed_neg got %h want ffff8001", rd);
    end
  endtask

  task automatic test_errors();
    int lat, p; logic [31:0] rd; logic er;
    txn(0, 1, 2'b01, 0, 32'h13, 32'h0000FFFF, lat, rd, er, p);
    vecs++;
    if (lat !== 1 || er !== 1'b1 || p !== 1 || rdata_a !== 32'hFFFF8001) begin
      miscompares++;
      $display("FAIL err_misaligned got lat=%0d err=%b pulses=%0d rdata=%h want 1 1 1 ffff8001", lat, er, p, rdata_a);
    end
    txn(0, 0, 2'b11, 0, 32'h10, 32'h0, lat, rd, er, p);
    vecs++;
    if (lat !== 1 || er !== 1'b1 || rdata_a !== 32'hFFFF8001) begin
      miscompares++;
      $display("FAIL err_size got lat=%0d err=%b rdata=%h want 1 1 ffff8001", lat, er, rdata_a);
    end
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'h1234AB78 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL err_no_write got %h err=%b want 1234ab78 0", rd, er);
    end
  endtask

  task automatic test_held_req();
    logic [14:0] busyv, rdyv, exp_busy, exp_rdy;
    @(negedge CLK);
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
    req_a = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge CLK);
      #1;
      busyv[k] = busy_a;
      rdyv[k]  = ready_a;
      exp_busy[k] = ((k % 5) != 4);
      exp_rdy[k]  = ((k % 5) == 3);
    end
    req_a = 1'b0;
    for (int k = 0; k < 10 && busy_a; k++) begin
      @(posedge CLK);
      #1;
    end
    vecs++;
    if (busyv !== exp_busy) begin
      miscompares++;
      $display("FAIL held_busy got %b want %b", busyv, exp_busy);
    end
    vecs++;
    if (rdyv !== exp_rdy) begin
      miscompares++;
      $display("FAIL held_ready got %b want %b", rdyv, exp_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, p; logic [31:0] rd; logic er;
    txn(0, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF, lat, rd, er, p);
    @(negedge CLK);
    we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h0;
    req_a = 1'b1;
    @(posedge CLK);
    #1;
    req_a = 1'b0;
    @(posedge CLK);
    #1;
    vecs++;
    if (busy_a !== 1'b1 || rdata_a === 32'd0) begin
      miscompares++;
      $display("FAIL pre_reset got busy=%b rdata=%h want busy 1 rdata nonzero", busy_a, rdata_a);
    end
    Reset = 1'b0;
    #1;
    vecs++;
    if ({rdata_a, ready_a, err_a, busy_a} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset got rdata=%h ready=%b err=%b busy=%b want all 0", rdata_a, ready_a, err_a, busy_a);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    txn(0, 0, 2'b10, 0, 32'h20, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL reset_no_write got %h want deadbeef", rd);
    end
  endtask

  task automatic test_wrap();
    int lat, p; logic [31:0] rd; logic er;
    txn(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, lat, rd, er, p);
    txn(0, 0, 2'b10, 0, 32'h000, 32'h0, lat, rd, er, p);
    vecs++;
    if (rd !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL addr_wrap got %h want cafef00d", rd);
    end
  endtask

  task automatic test_wait0();
    int lat, p; logic [31:0] rd; logic er;
    txn(1, 1, 2'b10, 0, 32'h08, 32'h55AA33CC, lat, rd, er, p);
    vecs++;
    if (lat !== 1 || p !== 1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL w0_store got lat=%0d pulses=%0d err=%b want 1 1 0", lat, p, er);
    end
    txn(1, 0, 2'b00, 1, 32'h0B, 32'h0, lat, rd, er, p);
    vecs++;
    if (lat !== 1 || rd !== 32'h00000055) begin
      miscompares++;
      $display("FAIL w0_load got lat=%0d rdata=%h want 1 00000055", lat, rd);
    end
    txn(1, 0, 2'b10, 0, 32'h0A, 32'h0, lat, rd, er, p);
    vecs++;
    if (lat !== 1 || er !== 1'b1 || rdata_b !== 32'h00000055) begin
      miscompares++;
      $display("FAIL w0_err got lat=%0d err=%b rdata=%h want 1 1 00000055", lat, er, rdata_b);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_held_req();
    test_reset_mid();
    test_wrap();
    test_wait0();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
